fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  IF stage of the 5-stage pipeline; producer of the inst/pc pair the decode stage registers.
//  Keeps the fetch PC and issues one instruction-memory request at a time (req/gnt, then rvalid).
//  Presents inst/pc for one cycle per fetched instruction, and a NOP bubble when none is ready.
//  Obeys stall, redirects on jal_flush/branch_flush, and discards fetches that a redirect made stale.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INST  32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous reset, active-high
//  stall          in   1   hazard: decode is holding; inst/pc must stay stable
//  jal_flush      in   1   redirect to jal_target
//  branch_flush   in   1   redirect to branch_target; wins over jal_flush
//  jal_target     in   32  redirect address for jal_flush
//  branch_target  in   32  redirect address for branch_flush
//  imem_req       out  1   request valid
//  imem_addr      out  32  word address of the request (bits[1:0]=00)
//  imem_gnt       in   1   request accepted this cycle
//  imem_rvalid    in   1   response data valid
//  imem_rdata     in   32  instruction word
//  inst           out  32  instruction to decode (registered)
//  pc             out  32  address of inst (registered)
// BEHAVIOUR
//  Reset (rst=1 at posedge, also mid-operation): state=S_REQ, fetch_pc=RESET_PC, inst=NOP_INST,
//   pc=0, discard=0, hold buffer empty. Any rvalid arriving after reset, while in S_REQ, is ignored.
//  flush = branch_flush | jal_flush.
//  target = branch_flush ? branch_target : jal_target, with bits[1:0] forced to 00.
//  imem_req = (state==S_REQ) & ~flush & ~rst, combinational. imem_addr = fetch_pc, always.
//  S_REQ: on imem_req & imem_gnt -> fetch_pc += 4 (mod 2^32, wraps), go to S_WAIT.
//   No grant -> req and addr held stable, no state change.
//  S_WAIT: wait for imem_rvalid.
//   rvalid & discard  -> drop the data, discard=0, go to S_REQ.
//   rvalid & ~stall   -> inst<=rdata, pc<=fetch_pc-4, go to S_REQ.
//   rvalid & stall    -> buffer {rdata, fetch_pc-4}, go to S_HOLD.
//  S_HOLD: no requests issued. On ~stall: inst/pc <= buffer, go to S_REQ.
//  Output rule (applies when no flush):
//   stall=1 -> inst/pc hold their values.
//   stall=0 with no new instruction this cycle -> inst<=NOP_INST; pc holds.
//  Flush (overrides stall and overrides the state actions above):
//   fetch_pc<=target; inst<=NOP_INST; hold buffer cleared.
//   In S_WAIT without rvalid: set discard=1 and stay in S_WAIT.
//   In S_WAIT with rvalid: drop the data and go to S_REQ.
//   In S_REQ or S_HOLD: go to S_REQ.
//  Latency: with gnt in cycle N and rvalid in N+1, inst is visible after the N+1 edge.
//   Peak throughput is 1 instruction per 2 cycles.
//  At most one request outstanding; rvalid seen in S_REQ or S_HOLD is ignored.
// TESTING
//  1 Reset release; gnt=1; rvalid 1 cycle after gnt; rdata=0x00500093.
//    -> addr 0x0 then 0x4; inst=0x00500093, pc=0x0 for one cycle; NOP between fetches.
//  2 stall=1 across rvalid (rdata=0x002081B3) for 3 cycles.
//    -> inst/pc unchanged and imem_req=0 while stalled; inst=0x002081B3 the cycle after release.
//  3 branch_flush in S_WAIT (target 0x100), rvalid 2 cycles later.
//    -> data dropped; inst=NOP; next imem_addr=0x100.
//  4 jal_flush and branch_flush together (targets 0x40 / 0x80).
//    -> next imem_addr=0x80; inst=NOP.
//  5 gnt held low 4 cycles at addr 0x8.
//    -> imem_req=1 and imem_addr=0x8 stable; fetch_pc does not advance.
//  6 rst in S_WAIT, then stale rvalid.
//    -> inst=NOP, pc=0; stale data ignored; next addr=RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// IF stage: owns the fetch PC, runs one req/gnt/rvalid transaction at a time
// and hands inst/pc to decode, honouring stall and branch/jal redirects.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jal_flush,
    input  logic        branch_flush,
    input  logic [31:0] jal_target,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic        flush;
    logic [31:0] target;
    logic        deliver;

    assign flush     = branch_flush | jal_flush;
    assign target    = (branch_flush ? branch_target : jal_target) & 32'hFFFF_FFFC;
    assign imem_req  = (state_q == S_REQ) & ~flush & ~rst;
    assign imem_addr = fetch_pc_q;
    assign inst      = inst_q;
    assign pc        = pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        deliver    = 1'b0;

        if (flush) begin
            fetch_pc_d = target;
            inst_d     = NOP_INST;
            state_d    = S_REQ;
            discard_d  = 1'b0;
            // An in-flight response still has to be absorbed before the next request
            if (state_q == S_WAIT && !imem_rvalid) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (!stall) begin
                            inst_d  = imem_rdata;
                            pc_d    = fetch_pc_q - 32'd4;
                            deliver = 1'b1;
                        end else begin
                            buf_inst_d = imem_rdata;
                            buf_pc_d   = fetch_pc_q - 32'd4;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_d  = buf_inst_q;
                        pc_d    = buf_pc_q;
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (!deliver && !stall) begin
                inst_d = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC_A;
            inst_q     <= NOP_INST;
            pc_q       <= 32'd0;
            discard_q  <= 1'b0;
            buf_inst_q <= NOP_INST;
            buf_pc_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, hand sequences for reset/discard,
// then random traffic against a transaction-level reference model.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, jal_flush, branch_flush;
    logic [31:0] jal_target, branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst, pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jal_flush(jal_flush), .branch_flush(branch_flush),
        .jal_target(jal_target), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .inst(inst), .pc(pc)
    );

    typedef struct {
        bit          rst, stall, jf, bf, gnt, rv;
        logic [31:0] rdata, jt, bt;
        bit          cc;
        bit          e_req;
        logic [31:0] e_addr, e_inst, e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] adr;
    } item_t;

    // Reference model: one outstanding transaction plus a hold queue
    bit          m_out, m_stale;
    logic [31:0] m_out_addr, m_pc, m_inst, m_opc;
    item_t       m_held[$];

    function automatic bit m_req();
        return !rst && !(jal_flush || branch_flush) && !m_out && m_held.size() == 0;
    endfunction

    task automatic model_step();
        bit got;
        item_t it;
        logic [31:0] tgt;
        got = 0;
        if (rst) begin
            m_out = 0; m_stale = 0; m_held.delete();
            m_pc = RPC; m_inst = NOP; m_opc = 0;
        end else if (jal_flush || branch_flush) begin
            tgt = branch_flush ? branch_target : jal_target;
            tgt[1:0] = 2'b00;
            if (m_out) begin
                if (imem_rvalid) begin m_out = 0; m_stale = 0; end
                else m_stale = 1;
            end
            m_held.delete();
            m_inst = NOP;
            m_pc = tgt;
        end else begin
            if (m_out) begin
                if (imem_rvalid) begin
                    m_out = 0;
                    if (m_stale) m_stale = 0;
                    else if (!stall) begin
                        m_inst = imem_rdata; m_opc = m_out_addr; got = 1;
                    end else begin
                        it.ins = imem_rdata; it.adr = m_out_addr;
                        m_held.push_back(it);
                    end
                end
            end else if (m_held.size() != 0) begin
                if (!stall) begin
                    it = m_held.pop_front();
                    m_inst = it.ins; m_opc = it.adr; got = 1;
                end
            end else if (imem_gnt) begin
                m_out = 1; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
            end
            if (!got && !stall) m_inst = NOP;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, bit s, bit jf, bit bf, bit g, bit rv,
                                logic [31:0] rd, logic [31:0] jt, logic [31:0] bt,
                                bit cc, bit er, logic [31:0] ea,
                                logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.rst = r; v.stall = s; v.jf = jf; v.bf = bf; v.gnt = g; v.rv = rv;
        v.rdata = rd; v.jt = jt; v.bt = bt; v.cc = cc;
        v.e_req = er; v.e_addr = ea; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst; stall = v.stall; jal_flush = v.jf; branch_flush = v.bf;
        imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
        jal_target = v.jt; branch_target = v.bt;
    endtask

    task automatic run_row(input vec_t v, input string tag);
        apply(v);
        #1;
        if (v.cc) begin
            chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, v.e_req});
            chk({tag, ".addr"}, imem_addr, v.e_addr);
        end
        @(posedge clk);
        model_step();
        #1;
        chk({tag, ".inst"}, inst, v.e_inst);
        chk({tag, ".pc"}, pc, v.e_pc);
    endtask

    vec_t tbl[$];

    initial begin
        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,NOP,0));

        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0, NOP,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0, NOP,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,0, NOP,0));
        tbl.push_back(mk(0,0,0,0,1,1,32'h00500093,0,0, 1,0,4, 32'h00500093,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,4, NOP,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h00500093,0,0, 1,0,8, 32'h00500093,4));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,8, NOP,4));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,8, NOP,4));
        tbl.push_back(mk(0,1,0,0,0,1,32'h002081B3,0,0, 1,0,32'hC, NOP,4));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 1,0,32'hC, NOP,4));
        tbl.push_back(mk(0,1,0,0,1,1,32'hDEADBEEF,0,0, 1,0,32'hC, NOP,4));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,32'hC, 32'h002081B3,8));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,32'hC, NOP,8));
        tbl.push_back(mk(0,0,0,1,0,0,0,32'h40,32'h100, 1,0,32'h10, NOP,8));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,32'h100, NOP,8));
        tbl.push_back(mk(0,0,0,0,0,1,32'h11111111,0,0, 1,0,32'h100, NOP,8));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,32'h100, NOP,8));
        tbl.push_back(mk(0,0,0,0,0,1,32'h00A00113,0,0, 1,0,32'h104, 32'h00A00113,32'h100));
        tbl.push_back(mk(0,0,1,1,1,0,0,32'h40,32'h80, 1,0,32'h104, NOP,32'h100));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,32'h80, NOP,32'h100));
        tbl.push_back(mk(0,0,1,0,0,1,32'h22222222,32'h43,0, 1,0,32'h84, NOP,32'h100));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,32'h40, NOP,32'h100));
        tbl.push_back(mk(0,0,0,0,0,1,32'h00000033,0,0, 1,0,32'h44, 32'h33,32'h40));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 1,1,32'h44, 32'h33,32'h40));
        tbl.push_back(mk(0,1,0,1,1,0,0,0,32'hFFFFFFFF, 1,0,32'h44, NOP,32'h40));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 1,1,32'hFFFFFFFC, NOP,32'h40));
        tbl.push_back(mk(0,0,0,0,0,1,32'h12345678,0,0, 1,0,32'h0, 32'h12345678,32'hFFFFFFFC));

        foreach (tbl[i]) run_row(tbl[i], $sformatf("vec%0d", i));

        // Reset while a fetch is in flight; the late response must be ignored
        run_row(mk(0,0,0,0,1,0,0,0,0, 1,1,0, NOP,32'hFFFFFFFC), "rst.grant");
        run_row(mk(1,0,0,0,0,0,0,0,0, 1,0,4, NOP,0), "rst.assert");
        run_row(mk(0,0,0,0,0,1,32'hBAD0BAD0,0,0, 1,1,RPC, NOP,0), "rst.stale");
        run_row(mk(0,0,0,0,1,0,0,0,0, 1,1,RPC, NOP,0), "rst.refetch");
        run_row(mk(0,0,0,0,0,1,32'h00100073,0,0, 1,0,4, 32'h00100073,0), "rst.data");

        // Discarded response must not be buffered even under stall
        run_row(mk(0,0,0,0,1,0,0,0,0, 1,1,4, NOP,0), "dis.grant");
        run_row(mk(0,0,1,0,0,0,0,32'h200,0, 1,0,8, NOP,0), "dis.flush");
        run_row(mk(0,1,0,0,0,1,32'hAAAAAAAA,0,0, 1,0,32'h200, NOP,0), "dis.drop");
        run_row(mk(0,0,0,0,0,0,0,0,0, 1,1,32'h200, NOP,0), "dis.after");

        // Randomized traffic against the reference model
        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,NOP,0));
        @(posedge clk); model_step(); #1;
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 9) < 3);
            jal_flush     = ($urandom_range(0, 99) < 7);
            branch_flush  = ($urandom_range(0, 99) < 7);
            jal_target    = $urandom;
            branch_target = $urandom;
            imem_gnt      = $urandom_range(0, 1) == 1;
            imem_rvalid   = ($urandom_range(0, 9) < 6);
            imem_rdata    = $urandom;
            #1;
            chk("rnd.req", {31'd0, imem_req}, {31'd0, m_req()});
            chk("rnd.addr", imem_addr, m_pc);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd.inst", inst, m_inst);
            chk("rnd.pc", pc, m_opc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
